// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one memory read channel between ICache and DCache refills.
// Latency: issues a request one cycle after it is latched; rvalid and rdata pass through with no added cycles.
// Backpressure: each port takes one outstanding request (x_rrdy = !pending); a request is issued only when dev_rrdy=1 in IDLE.
module mem_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int BLK_W  = 128,
    parameter int CNT_W  = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    input  logic [3:0]        i_ren,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              i_rrdy,
    output logic              i_rvalid,
    output logic [BLK_W-1:0]  i_rdata,
    input  logic [3:0]        d_ren,
    input  logic [ADDR_W-1:0] d_raddr,
    output logic              d_rrdy,
    output logic              d_rvalid,
    output logic [BLK_W-1:0]  d_rdata,
    input  logic              dev_rrdy,
    output logic [3:0]        dev_ren,
    output logic [ADDR_W-1:0] dev_raddr,
    input  logic              dev_rvalid,
    input  logic [BLK_W-1:0]  dev_rdata,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t             r_state;
    logic               r_grant;
    logic               r_last_grant;
    logic               r_pend_i;
    logic               r_pend_d;
    logic [3:0]         r_ren_i;
    logic [3:0]         r_ren_d;
    logic [ADDR_W-1:0]  r_raddr_i;
    logic [ADDR_W-1:0]  r_raddr_d;
    logic [3:0]         r_dev_ren;
    logic [ADDR_W-1:0]  r_dev_raddr;
    logic [CNT_W-1:0]   r_i_cnt;
    logic [CNT_W-1:0]   r_d_cnt;

    logic               w_win;
    logic               w_i_cmpl;
    logic               w_d_cmpl;

    // A lone pending port wins outright; on a tie the port that was not served last wins.
    always_comb begin
        w_win = r_pend_d;
        if (r_pend_i && r_pend_d) begin
            w_win = ~r_last_grant;
        end
    end

    assign w_i_cmpl = (r_state == S_WAIT) && dev_rvalid && (r_grant == PORT_I);
    assign w_d_cmpl = (r_state == S_WAIT) && dev_rvalid && (r_grant == PORT_D);

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_pend_i  <= 1'b0;
            r_ren_i   <= '0;
            r_raddr_i <= '0;
        end else if (w_i_cmpl) begin
            r_pend_i  <= 1'b0;
        end else if ((i_ren != 4'd0) && !r_pend_i) begin
            r_pend_i  <= 1'b1;
            r_ren_i   <= i_ren;
            r_raddr_i <= i_raddr;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_pend_d  <= 1'b0;
            r_ren_d   <= '0;
            r_raddr_d <= '0;
        end else if (w_d_cmpl) begin
            r_pend_d  <= 1'b0;
        end else if ((d_ren != 4'd0) && !r_pend_d) begin
            r_pend_d  <= 1'b1;
            r_ren_d   <= d_ren;
            r_raddr_d <= d_raddr;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state      <= S_IDLE;
            r_grant      <= PORT_I;
            r_last_grant <= PORT_I;
            r_dev_ren    <= '0;
            r_dev_raddr  <= '0;
            r_i_cnt      <= '0;
            r_d_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dev_ren <= '0;
                    if ((r_pend_i || r_pend_d) && dev_rrdy) begin
                        r_grant <= w_win;
                        r_state <= S_WAIT;
                        if (w_win == PORT_D) begin
                            r_dev_ren   <= r_ren_d;
                            r_dev_raddr <= r_raddr_d;
                            if (r_d_cnt != '1) r_d_cnt <= r_d_cnt + CNT_W'(1);
                        end else begin
                            r_dev_ren   <= r_ren_i;
                            r_dev_raddr <= r_raddr_i;
                            if (r_i_cnt != '1) r_i_cnt <= r_i_cnt + CNT_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    // Enable is a single-cycle pulse; the address stays up until data returns.
                    r_dev_ren <= '0;
                    if (dev_rvalid) begin
                        r_last_grant <= r_grant;
                        r_dev_raddr  <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_rrdy      = ~r_pend_i;
    assign d_rrdy      = ~r_pend_d;
    assign i_rvalid    = w_i_cmpl;
    assign d_rvalid    = w_d_cmpl;
    assign i_rdata     = dev_rdata;
    assign d_rdata     = dev_rdata;
    assign dev_ren     = r_dev_ren;
    assign dev_raddr   = r_dev_raddr;
    assign i_grant_cnt = r_i_cnt;
    assign d_grant_cnt = r_d_cnt;

endmodule
